// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Default width, funct3 opcodes and FSM state encoding.
package muldiv_pkg;
    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/muldiv_step.sv
// Shared adder/subtractor for one multiply or divide iteration.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module muldiv_step #(
    parameter int W = 33
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout
);
    // For subtraction, cout=1 means no borrow (x >= y).
    assign {cout, sum} = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{W{1'b0}}, sub};
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide, one bit per cycle on operand magnitudes.
// Latency: XLEN+1 cycles start->done; divide-by-zero and signed overflow take 1 cycle.
// Backpressure: start accepted only in IDLE/DONE; busy high while iterating; flush aborts.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    state_t          state;
    logic [2:0]      op;
    logic [5:0]      cnt;
    logic [XLEN:0]   acc;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] mb;
    logic            neg;
    logic            sa;

    logic            sa_in, sb_in, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   step_x, step_y, step_sum;
    logic            step_sub, step_cout;
    logic [XLEN:0]   nxt_acc;
    logic [XLEN-1:0] nxt_lo;
    logic [2*XLEN-1:0] prod, prod_c;
    logic [XLEN-1:0] quo_c, rem_c, fin;

    always_comb begin
        sa_in    = a[XLEN-1] & (funct3 == F3_MULH || funct3 == F3_MULHSU ||
                                funct3 == F3_DIV  || funct3 == F3_REM);
        sb_in    = b[XLEN-1] & (funct3 == F3_MULH || funct3 == F3_DIV || funct3 == F3_REM);
        mag_a    = sa_in ? -a : a;
        mag_b    = sb_in ? -b : b;
        div_zero = funct3[2] && (b == '0);
        div_ovf  = (funct3 == F3_DIV || funct3 == F3_REM) &&
                   (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    end

    // Divide: shift remainder left, trial-subtract divisor. Multiply: conditional add of b.
    always_comb begin
        if (op[2]) begin
            step_x   = {acc[XLEN-1:0], lo[XLEN-1]};
            step_y   = {1'b0, mb};
            step_sub = 1'b1;
        end else begin
            step_x   = acc;
            step_y   = lo[0] ? {1'b0, mb} : '0;
            step_sub = 1'b0;
        end
    end

    muldiv_step #(.W(XLEN+1)) u_step (
        .x    (step_x),
        .y    (step_y),
        .sub  (step_sub),
        .sum  (step_sum),
        .cout (step_cout)
    );

    always_comb begin
        if (op[2]) begin
            nxt_acc = step_cout ? step_sum : step_x;
            nxt_lo  = {lo[XLEN-2:0], step_cout};
        end else begin
            nxt_acc = {1'b0, step_sum[XLEN:1]};
            nxt_lo  = {step_sum[0], lo[XLEN-1:1]};
        end
        prod   = {nxt_acc[XLEN-1:0], nxt_lo};
        prod_c = neg ? -prod : prod;
        quo_c  = neg ? -nxt_lo : nxt_lo;
        rem_c  = sa ? -nxt_acc[XLEN-1:0] : nxt_acc[XLEN-1:0];
        case (op)
            F3_MUL:                       fin = prod_c[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin = prod_c[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fin = quo_c;
            default:                      fin = rem_c;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            op     <= '0;
            cnt    <= '0;
            acc    <= '0;
            lo     <= '0;
            mb     <= '0;
            neg    <= 1'b0;
            sa     <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_CALC: begin
                    acc <= nxt_acc;
                    lo  <= nxt_lo;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(XLEN-1)) begin
                        state  <= ST_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= fin;
                    end
                end
                default: begin
                    if (start) begin
                        op  <= funct3;
                        cnt <= '0;
                        neg <= sa_in ^ sb_in;
                        sa  <= sa_in;
                        if (div_zero || div_ovf) begin
                            // Both special cases: remainder is a (or 0), quotient is -1 (or a).
                            if (div_zero)
                                result <= funct3[1] ? a : '1;
                            else
                                result <= funct3[1] ? '0 : a;
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            acc   <= '0;
                            lo    <= mag_a;
                            mb    <= mag_b;
                            state <= ST_CALC;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected result and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result 0x%08h at cycle %0d, none expected", result, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", result, e.res);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Drive one request in the current cycle; it is sampled at the next rising edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] exp, input int lat, input bit want_done);
        start  = 1'b1;
        funct3 = f;
        a      = aa;
        b      = bb;
        if (want_done) sbq.push_back('{res: exp, cyc: cyc + lat});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] exp, input int lat);
        issue(f, aa, bb, exp, lat, 1'b1);
        wait_drain();
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = '0;
        a      = '0;
        b      = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_done",   32'(done),   32'd0);
        chk("reset_result", result,      32'd0);

        // Start presented together with reset release; busy high exactly for the 32 CALC cycles.
        rst_n = 1'b1;
        issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            chk($sformatf("mul_busy_c%0d", k), 32'(busy), (k <= 32) ? 32'd1 : 32'd0);
            if (k < 33) @(negedge clk);
        end
        wait_drain();

        run(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run(F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
        run(F3_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 1);
        run(F3_REMU,   32'd100,       32'd0,         32'd100,       1);
        run(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run(F3_DIVU,   32'd100,       32'd7,         32'd14,        33);
        run(F3_REMU,   32'd100,       32'd7,         32'd2,         33);
        run(F3_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run(F3_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33);
        run(F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);

        // Back-to-back: new start accepted in the DONE cycle of the previous op.
        issue(F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_done_seen", 32'(done), 32'd1);
        issue(F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1);
        wait_drain();

        // Flush on the 10th CALC cycle: no done, result keeps the previous value.
        issue(F3_MUL, 32'd3, 32'd5, 32'd0, 0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_result_held", result, 32'hFFFF_FFFF);
        chk("flush_idle_busy",   32'(busy), 32'd0);

        // Start ignored while iterating: a late DIVU must not replace the running MUL.
        issue(F3_MUL, 32'd6, 32'd7, 32'd42, 33, 1'b1);
        repeat (4) @(negedge clk);
        issue(F3_DIVU, 32'd9, 32'd0, 32'd0, 0, 1'b0);
        wait_drain();

        // Asynchronous reset mid-CALC clears outputs without waiting for a clock edge.
        issue(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 0, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",   32'(busy), 32'd0);
        chk("arst_done",   32'(done), 32'd0);
        chk("arst_result", result,    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(F3_REMU, 32'd100, 32'd0, 32'd100, 1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request; sampled only when ready.
REQ-005 SHALL have port: funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: a  input  XLEN  rs1 operand / dividend.
REQ-007 SHALL have port: b  input  XLEN  rs2 operand / divisor.
REQ-008 SHALL have port: flush  input  1  pipeline kill; abort current operation.
REQ-009 SHALL have port: busy  output  1  high while operation in progress; pipeline stalls on busy|start.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port: result  output  XLEN  registered result; held until next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; ready = (IDLE or DONE).
REQ-013 SHALL accept start when ready and flush=0: latch funct3, operand magnitudes, sign flags; clear 6-bit counter; go CALC.
REQ-014 SHALL iterate one bit per cycle in CALC: shift-add multiply (2*XLEN product) or restoring divide (XLEN+1-bit partial remainder).
REQ-015 SHALL go CALC->DONE after exactly XLEN iterations; start sampled cycle N -> done=1 in cycle N+XLEN+1 (N+33).
REQ-016 SHALL apply sign correction on CALC->DONE: product negated if signs differ (MULH: both signed; MULHSU: a only); quotient negated if signs differ; remainder takes dividend sign.
REQ-017 SHALL select result: MUL low XLEN bits; MULH* high XLEN bits; DIV* quotient; REM* remainder.
REQ-018 SHALL, on divide by zero (b=0), skip CALC: DONE in N+1, quotient all-ones, remainder = a.
REQ-019 SHALL, on signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF), skip CALC: DONE in N+1, quotient 0x80000000, remainder 0.
REQ-020 SHALL go DONE->IDLE next cycle unless start accepted in DONE (back-to-back: DONE->CALC).
REQ-021 SHALL ignore start while in CALC.
REQ-022 SHALL, on flush in any state, go IDLE next edge, no done pulse, result unchanged; flush has priority over simultaneous start.
REQ-023 SHALL drive busy=1 exactly in CALC; done=1 exactly in DONE.

Reset
REQ-024 SHALL, on rst_n=0 (asynchronous, any state incl. mid-CALC): state IDLE, busy=0, done=0, result=0, counter=0, internal operands 0.
REQ-025 SHALL accept start on first rising edge after rst_n deasserts.

Structure
REQ-026 SHALL place XLEN default, funct3 encodings, and FSM state encoding in shared package muldiv_pkg.
REQ-027 SHALL use one combinational sub-module muldiv_step (XLEN+1-bit add/subtract with carry) shared by multiply and divide iteration; all else in muldiv_unit.

Verification
REQ-028 SHALL test MUL a=7, b=0xFFFFFFFD, start cycle 0 -> done cycle 33, result 0xFFFFFFEB, busy high cycles 1-32.
REQ-029 SHALL test MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-030 SHALL test DIVU a=100, b=0 -> done cycle 1, result 0xFFFFFFFF; REMU same -> 100; DIV 0x80000000/0xFFFFFFFF -> done cycle 1, 0x80000000.
REQ-031 SHALL test REM a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFF; DIV same -> 0xFFFFFFFD; back-to-back start in DONE -> second done exactly 33 cycles later.
REQ-032 SHALL test flush at cycle 10 of CALC -> busy=0 cycle 11, no done, result holds prior value; rst_n pulse mid-CALC -> all outputs 0 immediately.
